// File: rtl/reg_bank_pkg.sv
// Shared datapath constants for the register file and the write-register selector.
// Holds the fixed register indices, reset defaults and index type.
package reg_bank_pkg;

    localparam int unsigned IDX_W            = 5;
    localparam int unsigned NUM_REGS         = 32;
    localparam int unsigned DATA_W_DEFAULT   = 32;
    localparam int unsigned SP_RESET_DEFAULT = 227;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    // Register 0 is architecturally zero: it is never stored and always reads 0.
    function automatic logic idx_is_zero(input reg_idx_t idx);
        return idx == REG_ZERO;
    endfunction

endpackage : reg_bank_pkg

// File: rtl/reg_bank_read_port.sv
// One combinational read port: zero-masks index 0 and bypasses a same-cycle write.
module reg_bank_read_port
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  reg_idx_t          rd_idx,
    input  logic [DATA_W-1:0] arr_word,
    input  logic              wr_en,
    input  reg_idx_t          wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_c
);

    logic hit_c;

    always_comb begin
        hit_c     = wr_en && (wr_idx == rd_idx);
        rd_data_c = arr_word;
        if (idx_is_zero(rd_idx)) begin
            rd_data_c = '0;
        end else if (hit_c) begin
            rd_data_c = wr_data;
        end
    end

endmodule : reg_bank_read_port

// File: rtl/reg_bank.sv
// 32-entry architectural register file with two bypassed read ports
// and the registered A/B operand latches feeding the ALU stage.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned SP_RESET = SP_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  reg_idx_t          write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  reg_idx_t          read_reg1,
    input  reg_idx_t          read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              load_ab,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    localparam logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              wr_en_c;

    assign wr_en_c = reg_write && !idx_is_zero(write_reg);

    // Array next state: only the single write port updates storage.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_c) begin
            mem_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    reg_bank_read_port #(
        .DATA_W (DATA_W)
    ) u_port1 (
        .rd_idx    (read_reg1),
        .arr_word  (mem_q[read_reg1]),
        .wr_en     (reg_write),
        .wr_idx    (write_reg),
        .wr_data   (write_data),
        .rd_data_c (read_data1)
    );

    reg_bank_read_port #(
        .DATA_W (DATA_W)
    ) u_port2 (
        .rd_idx    (read_reg2),
        .arr_word  (mem_q[read_reg2]),
        .wr_en     (reg_write),
        .wr_idx    (write_reg),
        .wr_data   (write_data),
        .rd_data_c (read_data2)
    );

    // Operand latches capture post-bypass read data so a same-cycle write is seen.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_ab) begin
            a_d = read_data1;
            b_d = read_data2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: reset sweep, a vector table, then mid-cycle reset.
module tb_reg_bank;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset_n;
    logic          reg_write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic [4:0]    read_reg1;
    logic [4:0]    read_reg2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          load_ab;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;

    int total = 0;
    int bad   = 0;

    reg_bank #(
        .DATA_W   (32),
        .SP_RESET (227)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .load_ab    (load_ab),
        .a_out      (a_out),
        .b_out      (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [4:0]    wr;
        logic [DW-1:0] wd;
        logic [4:0]    r1;
        logic [4:0]    r2;
        logic          ld;
        logic [DW-1:0] exp_rd1;
        logic [DW-1:0] exp_rd2;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [DW-1:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic ld);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        load_ab    = ld;
    endtask

    initial begin
        // State evolves across rows; after reset mem=0 except r29=227, A=B=0.
        vecs[0]  = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd29, 1'b0, 32'hDEADBEEF, 32'd227,     32'd0,      32'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 1'b1, 32'd0,        32'hDEADBEEF, 32'd0,     32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd0,  1'b1, 32'd0,        32'd0,        32'd0,     32'd0};
        vecs[3]  = '{1'b1, 5'd8,  32'h55AA,     5'd8,  5'd29, 1'b1, 32'h55AA,     32'd227,      32'h55AA,  32'd227};
        vecs[4]  = '{1'b1, 5'd8,  32'd1,        5'd8,  5'd31, 1'b0, 32'd1,        32'hDEADBEEF, 32'h55AA,  32'd227};
        vecs[5]  = '{1'b1, 5'd8,  32'd2,        5'd8,  5'd8,  1'b0, 32'd2,        32'd2,        32'h55AA,  32'd227};
        vecs[6]  = '{1'b1, 5'd8,  32'd3,        5'd8,  5'd0,  1'b0, 32'd3,        32'd0,        32'h55AA,  32'd227};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  1'b1, 32'd3,        32'd3,        32'd3,     32'd3};
        vecs[8]  = '{1'b0, 5'd29, 32'hFFFF0000, 5'd29, 5'd0,  1'b0, 32'd227,      32'd0,        32'd3,     32'd3};
        vecs[9]  = '{1'b1, 5'd5,  32'd7,        5'd5,  5'd31, 1'b0, 32'd7,        32'hDEADBEEF, 32'd3,     32'd3};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 32'd7,        32'd0,        32'd3,     32'd3};

        reset_n = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        check("reset_a", a_out, 32'd0);
        check("reset_b", b_out, 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), read_data1, (i == 29) ? 32'd227 : 32'd0);
            check($sformatf("reset_rd2_r%0d", 31 - i), read_data2, ((31 - i) == 29) ? 32'd227 : 32'd0);
        end

        // Drive after an edge, check comb reads mid-cycle, then A/B after the next edge.
        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r1, vecs[v].r2, vecs[v].ld);
            #3;
            check($sformatf("vec%0d_rd1", v), read_data1, vecs[v].exp_rd1);
            check($sformatf("vec%0d_rd2", v), read_data2, vecs[v].exp_rd2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_a", v), a_out, vecs[v].exp_a);
            check($sformatf("vec%0d_b", v), b_out, vecs[v].exp_b);
        end

        // Mid-cycle asynchronous reset clears A/B and array immediately.
        drive(1'b1, 5'd5, 32'd9, 5'd5, 5'd29, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_a", a_out, 32'd0);
        check("async_rst_b", b_out, 32'd0);
        reg_write = 1'b0;
        #1;
        check("async_rst_r5", read_data1, 32'd0);
        check("async_rst_r29", read_data2, 32'd227);

        // Reset held across an edge overrides a write and a load.
        drive(1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd29, 1'b1);
        @(posedge clk);
        #1;
        check("rst_hold_a", a_out, 32'd0);
        check("rst_hold_b", b_out, 32'd0);
        reg_write = 1'b0;
        #1;
        check("rst_hold_r31", read_data1, 32'd0);

        #2;
        reset_n = 1'b1;
        drive(1'b0, 5'd0, '0, 5'd31, 5'd29, 1'b1);
        @(posedge clk);
        #1;
        check("release_r31", read_data1, 32'd0);
        check("release_r29", read_data2, 32'd227);
        check("release_a", a_out, 32'd0);
        check("release_b", b_out, 32'd227);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_bank
